tri_incenter_seq: RTL and testbench

- Sequential, parametrised incenter engine for the NavIC position-geometry datapath.
- Takes one triangle per transaction as three signed 2-D vertices A, B, C.
- Returns the floored side lengths and the incenter (a·A + b·B + c·C)/(a+b+c), where a=|BC|, b=|CA|, c=|AB|.
- Replaces the combinational sqrt/divide chain with a single shared integer-sqrt unit and a shared divider, behind a valid/ready handshake.

---
 rtl/tri_incenter_seq_pkg.sv | 45 ++++
 rtl/tri_incenter_seq_if.sv | 38 +++
 rtl/tri_incenter_seq_isqrt.sv | 70 +++++++
 rtl/tri_incenter_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_tri_incenter_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/tri_incenter_seq_pkg.sv
// Shared geometry package: FSM state encoding, width helpers and the fixed
// transaction latency used by the incenter engine and its bench.
package tri_geom_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIFF,
        SQ,
        SQRT,
        WSUM,
        DIV,
        DONE
    } geom_state_e;

    // Edge difference of two W-bit signed coordinates.
    function automatic int diffWidth(input int w);
        return w + 1;
    endfunction

    // dx*dx + dy*dy of two diffWidth values, unsigned.
    function automatic int sqWidth(input int w);
        return 2 * w + 2;
    endfunction

    // floor(sqrt) of a sqWidth value.
    function automatic int lenWidth(input int w);
        return w + 1;
    endfunction

    // a*ax + b*bx + c*cx, signed.
    function automatic int sumWidth(input int w);
        return 2 * w + 4;
    endfunction

    // a + b + c, unsigned.
    function automatic int perWidth(input int w);
        return w + 3;
    endfunction

    // Cycles from the accepting edge to out_valid.
    function automatic int LAT(input int w);
        return 7 * w + 14;
    endfunction

endpackage

// File: rtl/tri_incenter_seq_if.sv
// Handshake and data bus of the incenter engine: vertex set in, side lengths
// and incenter out. The producer/consumer side uses master, the engine slave.
interface tri_incenter_seq_if
    import tri_geom_pkg::*;
#(
    parameter int W = 16
);
    localparam int LW = lenWidth(W);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  ax;
    logic signed [W-1:0]  ay;
    logic signed [W-1:0]  bx;
    logic signed [W-1:0]  by;
    logic signed [W-1:0]  cx;
    logic signed [W-1:0]  cy;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  ix;
    logic signed [W-1:0]  iy;
    logic [LW-1:0]        len_a;
    logic [LW-1:0]        len_b;
    logic [LW-1:0]        len_c;
    logic                 degen;
    logic                 busy;

    modport master (
        output in_valid, ax, ay, bx, by, cx, cy, out_ready,
        input  in_ready, out_valid, ix, iy, len_a, len_b, len_c, degen, busy
    );

    modport slave (
        input  in_valid, ax, ay, bx, by, cx, cy, out_ready,
        output in_ready, out_valid, ix, iy, len_a, len_b, len_c, degen, busy
    );

endinterface

// File: rtl/tri_incenter_seq_isqrt.sv
// Sequential restoring integer square root. One root bit per cycle; the
// start cycle already performs the first iteration on the fresh operand, so a
// run takes exactly IW/2 cycles and back-to-back runs need no gap. o_done
// pulses for one cycle right after the final iteration, when o_root is final.
module isqrt_seq #(
    parameter int IW = 34
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [IW-1:0]     i_operand,
    output logic              o_done,
    output logic [IW/2-1:0]   o_root
);
    localparam int HALF = IW / 2;
    localparam int RW   = HALF + 3;
    localparam int CW   = $clog2(HALF + 1);

    logic [IW-1:0]   r_op;
    logic [RW-1:0]   r_rem;
    logic [HALF-1:0] r_root;
    logic [CW-1:0]   r_count;
    logic            r_done;

    logic [IW-1:0]   w_srcOp;
    logic [RW-1:0]   w_srcRem;
    logic [HALF-1:0] w_srcRoot;
    logic [RW-1:0]   w_remShift;
    logic [RW-1:0]   w_trial;
    logic            w_fits;
    logic [RW-1:0]   w_remNext;
    logic [HALF-1:0] w_rootNext;
    logic            w_step;

    // One iteration: bring down the next bit pair and try subtracting 4q+1.
    always_comb begin
        w_srcOp    = i_start ? i_operand : r_op;
        w_srcRem   = i_start ? '0 : r_rem;
        w_srcRoot  = i_start ? '0 : r_root;
        w_remShift = {w_srcRem[RW-3:0], w_srcOp[IW-1 -: 2]};
        w_trial    = {1'b0, w_srcRoot, 2'b01};
        w_fits     = (w_remShift >= w_trial);
        w_remNext  = w_fits ? (w_remShift - w_trial) : w_remShift;
        w_rootNext = {w_srcRoot[HALF-2:0], w_fits};
        w_step     = i_start || (r_count != '0);
    end

    // Iteration registers advance while a run is active; done marks the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op    <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_step && !i_start && (r_count == CW'(1));
            if (w_step) begin
                r_op    <= {w_srcOp[IW-3:0], 2'b00};
                r_rem   <= w_remNext;
                r_root  <= w_rootNext;
                r_count <= i_start ? CW'(HALF - 1) : (r_count - CW'(1));
            end
        end
    end

    assign o_done = r_done;
    assign o_root = r_root;

endmodule

// File: rtl/tri_incenter_seq.sv
// Sequential incenter engine: registers a triangle, forms edge differences
// and squared norms, takes three square roots on one shared isqrt_seq, builds
// the weighted vertex sums and divides them by the perimeter on one shared
// restoring divider. Latency is fixed regardless of data.
module tri_incenter_seq
    import tri_geom_pkg::*;
#(
    parameter int W = 16
) (
    input  logic               clk,
    input  logic               rst,
    tri_incenter_seq_if.slave  bus
);
    localparam int DFW      = diffWidth(W);
    localparam int SW       = sqWidth(W);
    localparam int LW       = lenWidth(W);
    localparam int DW       = sumWidth(W);
    localparam int PW       = perWidth(W);
    localparam int SQRT_CYC = 3 * (W + 1);
    localparam int DIV_CYC  = 2 * DW;
    localparam int CW       = $clog2(DIV_CYC + 1);

    geom_state_e r_state;
    geom_state_e w_nextState;

    logic signed [W-1:0]   r_ax, r_ay, r_bx, r_by, r_cx, r_cy;
    logic signed [DFW-1:0] r_dAx, r_dAy, r_dBx, r_dBy, r_dCx, r_dCy;
    logic [SW-1:0]         r_sqA, r_sqB, r_sqC;
    logic [LW-1:0]         r_lenA, r_lenB, r_lenC;
    logic [1:0]            r_rootCount;
    logic [CW-1:0]         r_cnt;
    logic signed [DW-1:0]  r_sx, r_sy;
    logic [PW-1:0]         r_per;
    logic                  r_degen;
    logic [PW-1:0]         r_divRem;
    logic [DW-1:0]         r_divQuo;
    logic [W-1:0]          r_qx;

    logic signed [W-1:0]   r_ix, r_iy;
    logic [LW-1:0]         r_outLenA, r_outLenB, r_outLenC;
    logic                  r_outDegen;

    logic                  w_inReady;
    logic                  w_outValid;
    logic                  w_busy;

    logic                  w_sqrtStart;
    logic [SW-1:0]         w_sqrtOperand;
    logic                  w_sqrtDone;
    logic [LW-1:0]         w_root;
    logic [PW-1:0]         w_per;

    logic                  w_divLoad;
    logic [DW-1:0]         w_dividend;
    logic [PW-1:0]         w_divRemSrc;
    logic [DW-1:0]         w_divQuoSrc;
    logic [PW:0]           w_divShift;
    logic [PW:0]           w_divDiff;
    logic                  w_divFits;
    logic [PW-1:0]         w_divRemNext;
    logic [DW-1:0]         w_divQuoNext;

    function automatic logic [SW-1:0] normSq(input logic signed [DFW-1:0] dx,
                                             input logic signed [DFW-1:0] dy);
        logic signed [SW-1:0] ex;
        logic signed [SW-1:0] ey;
        ex = SW'(dx);
        ey = SW'(dy);
        return $unsigned(ex * ex) + $unsigned(ey * ey);
    endfunction

    function automatic logic signed [DW-1:0] weight(input logic [LW-1:0] len,
                                                    input logic signed [W-1:0] coord);
        logic signed [DW-1:0] el;
        logic signed [DW-1:0] ec;
        el = $signed(DW'(len));
        ec = DW'(coord);
        return el * ec;
    endfunction

    function automatic logic [DW-1:0] magnitude(input logic signed [DW-1:0] v);
        return v[DW-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    // Quotients lie inside the vertex bounding box, so the low W bits are exact.
    function automatic logic [W-1:0] applySign(input logic [DW-1:0] q, input logic neg);
        logic [DW-1:0] s;
        s = neg ? (-q) : q;
        return s[W-1:0];
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; every phase has a fixed duration.
    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            IDLE:    if (bus.in_valid) w_nextState = DIFF;
            DIFF:    w_nextState = SQ;
            SQ:      w_nextState = SQRT;
            SQRT:    if (r_cnt == CW'(SQRT_CYC - 1)) w_nextState = WSUM;
            WSUM:    w_nextState = DIV;
            DIV:     if (r_cnt == CW'(DIV_CYC - 1)) w_nextState = DONE;
            DONE:    if (bus.out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state alone.
    always_comb begin
        w_inReady  = (r_state == IDLE);
        w_outValid = (r_state == DONE);
        w_busy     = (r_state != IDLE);
    end

    // Phase cycle counter, restarted on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_nextState != r_state) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Shared square-root unit runs a, b, c back to back inside SQRT.
    always_comb begin
        w_sqrtStart = (r_state == SQRT) &&
                      ((r_cnt == '0) || (r_cnt == CW'(W + 1)) || (r_cnt == CW'(2 * (W + 1))));
        if (r_cnt < CW'(W + 1)) begin
            w_sqrtOperand = r_sqA;
        end else if (r_cnt < CW'(2 * (W + 1))) begin
            w_sqrtOperand = r_sqB;
        end else begin
            w_sqrtOperand = r_sqC;
        end
    end

    isqrt_seq #(
        .IW (SW)
    ) u_isqrt (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_sqrtStart),
        .i_operand (w_sqrtOperand),
        .o_done    (w_sqrtDone),
        .o_root    (w_root)
    );

    // Perimeter uses the c root straight from the sqrt unit during WSUM.
    always_comb begin
        w_per = PW'(r_lenA) + PW'(r_lenB) + PW'(w_root);
    end

    // Restoring divider step on magnitudes; loads a fresh dividend at each half of DIV.
    always_comb begin
        w_divLoad    = (r_state == DIV) && ((r_cnt == '0) || (r_cnt == CW'(DW)));
        w_dividend   = (r_cnt == '0) ? magnitude(r_sx) : magnitude(r_sy);
        w_divRemSrc  = w_divLoad ? '0 : r_divRem;
        w_divQuoSrc  = w_divLoad ? w_dividend : r_divQuo;
        w_divShift   = {w_divRemSrc, w_divQuoSrc[DW-1]};
        w_divDiff    = w_divShift - {1'b0, r_per};
        w_divFits    = (w_divShift >= {1'b0, r_per});
        w_divRemNext = w_divFits ? w_divDiff[PW-1:0] : w_divShift[PW-1:0];
        w_divQuoNext = {w_divQuoSrc[DW-2:0], w_divFits};
    end

    // Datapath registers for each phase and the result registers loaded on DIV->DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ax        <= '0;
            r_ay        <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_dAx       <= '0;
            r_dAy       <= '0;
            r_dBx       <= '0;
            r_dBy       <= '0;
            r_dCx       <= '0;
            r_dCy       <= '0;
            r_sqA       <= '0;
            r_sqB       <= '0;
            r_sqC       <= '0;
            r_lenA      <= '0;
            r_lenB      <= '0;
            r_lenC      <= '0;
            r_rootCount <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_per       <= '0;
            r_degen     <= 1'b0;
            r_divRem    <= '0;
            r_divQuo    <= '0;
            r_qx        <= '0;
            r_ix        <= '0;
            r_iy        <= '0;
            r_outLenA   <= '0;
            r_outLenB   <= '0;
            r_outLenC   <= '0;
            r_outDegen  <= 1'b0;
        end else begin
            if (r_state == IDLE && bus.in_valid) begin
                r_ax <= bus.ax;
                r_ay <= bus.ay;
                r_bx <= bus.bx;
                r_by <= bus.by;
                r_cx <= bus.cx;
                r_cy <= bus.cy;
            end

            if (r_state == DIFF) begin
                r_dAx       <= {r_cx[W-1], r_cx} - {r_bx[W-1], r_bx};
                r_dAy       <= {r_cy[W-1], r_cy} - {r_by[W-1], r_by};
                r_dBx       <= {r_ax[W-1], r_ax} - {r_cx[W-1], r_cx};
                r_dBy       <= {r_ay[W-1], r_ay} - {r_cy[W-1], r_cy};
                r_dCx       <= {r_bx[W-1], r_bx} - {r_ax[W-1], r_ax};
                r_dCy       <= {r_by[W-1], r_by} - {r_ay[W-1], r_ay};
                r_rootCount <= '0;
            end

            if (r_state == SQ) begin
                r_sqA <= normSq(r_dAx, r_dAy);
                r_sqB <= normSq(r_dBx, r_dBy);
                r_sqC <= normSq(r_dCx, r_dCy);
            end

            if (w_sqrtDone && (r_state == SQRT || r_state == WSUM)) begin
                r_rootCount <= r_rootCount + 2'd1;
                unique case (r_rootCount)
                    2'd0:    r_lenA <= w_root;
                    2'd1:    r_lenB <= w_root;
                    default: r_lenC <= w_root;
                endcase
            end

            if (r_state == WSUM) begin
                r_sx    <= weight(r_lenA, r_ax) + weight(r_lenB, r_bx) + weight(w_root, r_cx);
                r_sy    <= weight(r_lenA, r_ay) + weight(r_lenB, r_by) + weight(w_root, r_cy);
                r_per   <= w_per;
                r_degen <= (w_per == '0);
            end

            if (r_state == DIV) begin
                r_divRem <= w_divRemNext;
                r_divQuo <= w_divQuoNext;
                if (r_cnt == CW'(DW)) begin
                    r_qx <= applySign(r_divQuo, r_sx[DW-1]);
                end
                if (r_cnt == CW'(DIV_CYC - 1)) begin
                    r_ix       <= r_degen ? r_ax : $signed(r_qx);
                    r_iy       <= r_degen ? r_ay : $signed(applySign(w_divQuoNext, r_sy[DW-1]));
                    r_outLenA  <= r_lenA;
                    r_outLenB  <= r_lenB;
                    r_outLenC  <= r_lenC;
                    r_outDegen <= r_degen;
                end
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = w_outValid;
    assign bus.busy      = w_busy;
    assign bus.ix        = r_ix;
    assign bus.iy        = r_iy;
    assign bus.len_a     = r_outLenA;
    assign bus.len_b     = r_outLenB;
    assign bus.len_c     = r_outLenC;
    assign bus.degen     = r_outDegen;

endmodule

// File: tb/tb_tri_incenter_seq.sv
// Bench for tri_incenter_seq: directed triangles, backpressure, extremes,
// random triangles and a mid-run reset, each checked against an arithmetic
// reference of side lengths and incenter.
module tb_tri_incenter_seq;
    import tri_geom_pkg::*;

    localparam int W       = 16;
    localparam int LATENCY = LAT(W);

    logic clk = 1'b0;
    logic rst = 1'b0;

    tri_incenter_seq_if #(.W(W)) bus ();

    tri_incenter_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int     nAsserts = 0;
    int     nFails   = 0;
    longint expA, expB, expC, expIx, expIy;
    longint expDeg;

    task automatic checkValue(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] req);
        nAsserts++;
        assert (obs === req)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, req);
        end
    endtask

    function automatic longint floorSqrt(input longint n);
        longint r;
        r = longint'($sqrt(real'(n)));
        while (r * r > n) r--;
        while ((r + 1) * (r + 1) <= n) r++;
        return r;
    endfunction

    // Reference: side lengths, perimeter-weighted centroid, truncating division.
    task automatic model(input longint ax, input longint ay, input longint bx,
                         input longint by, input longint cx, input longint cy);
        longint p;
        expA   = floorSqrt((cx - bx) * (cx - bx) + (cy - by) * (cy - by));
        expB   = floorSqrt((ax - cx) * (ax - cx) + (ay - cy) * (ay - cy));
        expC   = floorSqrt((bx - ax) * (bx - ax) + (by - ay) * (by - ay));
        p      = expA + expB + expC;
        expDeg = (p == 0) ? 1 : 0;
        if (p == 0) begin
            expIx = ax;
            expIy = ay;
        end else begin
            expIx = (expA * ax + expB * bx + expC * cx) / p;
            expIy = (expA * ay + expB * by + expC * cy) / p;
        end
    endtask

    function automatic longint randCoord(input bit wide);
        logic [15:0] u;
        if (wide) begin
            u = 16'($urandom_range(0, 65535));
            return longint'($signed(u));
        end
        return longint'($urandom_range(0, 200)) - 100;
    endfunction

    task automatic applyStimulus(input string tag, input longint ax, input longint ay,
                                 input longint bx, input longint by,
                                 input longint cx, input longint cy);
        int waitCyc;
        waitCyc = 0;
        while (bus.in_ready !== 1'b1 && waitCyc < 300) begin
            @(posedge clk);
            #1;
            waitCyc++;
        end
        checkValue({tag, ".in_ready_idle"}, bus.in_ready, 1);
        model(ax, ay, bx, by, cx, cy);
        bus.in_valid = 1'b1;
        bus.ax = ax[W-1:0];
        bus.ay = ay[W-1:0];
        bus.bx = bx[W-1:0];
        bus.by = by[W-1:0];
        bus.cx = cx[W-1:0];
        bus.cy = cy[W-1:0];
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkValue({tag, ".busy"}, bus.busy, 1);
        checkValue({tag, ".in_ready_busy"}, bus.in_ready, 0);
    endtask

    task automatic waitResult(input string tag);
        int lat;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < LATENCY + 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkValue({tag, ".latency"}, lat, LATENCY);
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".out_valid"}, bus.out_valid, 1);
        checkValue({tag, ".len_a"}, bus.len_a, expA);
        checkValue({tag, ".len_b"}, bus.len_b, expB);
        checkValue({tag, ".len_c"}, bus.len_c, expC);
        checkValue({tag, ".ix"}, bus.ix, expIx);
        checkValue({tag, ".iy"}, bus.iy, expIy);
        checkValue({tag, ".degen"}, bus.degen, expDeg);
    endtask

    task automatic consumeResult(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkValue({tag, ".out_valid_drop"}, bus.out_valid, 0);
        checkValue({tag, ".in_ready_back"}, bus.in_ready, 1);
    endtask

    task automatic runTriangle(input string tag, input longint ax, input longint ay,
                               input longint bx, input longint by,
                               input longint cx, input longint cy);
        applyStimulus(tag, ax, ay, bx, by, cx, cy);
        waitResult(tag);
        checkOutput(tag);
        consumeResult(tag);
    endtask

    task automatic checkCleared(input string tag);
        checkValue({tag, ".in_ready"}, bus.in_ready, 1);
        checkValue({tag, ".out_valid"}, bus.out_valid, 0);
        checkValue({tag, ".busy"}, bus.busy, 0);
        checkValue({tag, ".ix"}, bus.ix, 0);
        checkValue({tag, ".iy"}, bus.iy, 0);
        checkValue({tag, ".len_a"}, bus.len_a, 0);
        checkValue({tag, ".len_b"}, bus.len_b, 0);
        checkValue({tag, ".len_c"}, bus.len_c, 0);
        checkValue({tag, ".degen"}, bus.degen, 0);
    endtask

    // Directed sequence followed by random triangles and a mid-run reset.
    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.ax = '0; bus.ay = '0; bus.bx = '0; bus.by = '0; bus.cx = '0; bus.cy = '0;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkCleared("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        runTriangle("right345", 0, 0, 4, 0, 0, 3);
        runTriangle("nonsquare", 0, 0, 10, 0, 5, 9);
        runTriangle("negative", -4, 0, 0, 0, -4, -3);
        runTriangle("degenerate", 7, -3, 7, -3, 7, -3);

        applyStimulus("backpressure", 3, 1, 20, 5, 8, 17);
        waitResult("backpressure");
        checkOutput("backpressure");
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.ax = 16'($urandom_range(0, 65535));
            bus.cy = 16'($urandom_range(0, 65535));
            @(posedge clk);
            #1;
            checkOutput("hold");
            checkValue("hold.in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        consumeResult("backpressure");

        runTriangle("extreme", -32768, -32768, 32767, -32768, -32768, 32767);

        for (int i = 0; i < 6; i++) begin
            bit wide;
            wide = (i % 2) == 1;
            runTriangle($sformatf("random%0d", i), randCoord(wide), randCoord(wide),
                        randCoord(wide), randCoord(wide), randCoord(wide), randCoord(wide));
        end

        applyStimulus("midreset", 0, 0, 4, 0, 0, 3);
        repeat (2 + 20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkCleared("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkValue("midreset.in_ready_after", bus.in_ready, 1);
        runTriangle("rerun345", 0, 0, 4, 0, 0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
